// File: rtl/sseg_pkg.sv
// Shared 7-segment constants: active-low glyphs {g,f,e,d,c,b,a} and scan-capture state encoding.
// The display encoder uses the same glyphs, so edit them here only.
package sseg_pkg;

    localparam logic [6:0] GLYPH_0   = 7'b1000000;
    localparam logic [6:0] GLYPH_1   = 7'b1111001;
    localparam logic [6:0] GLYPH_2   = 7'b0100100;
    localparam logic [6:0] GLYPH_3   = 7'b0110000;
    localparam logic [6:0] GLYPH_4   = 7'b0011001;
    localparam logic [6:0] GLYPH_5   = 7'b0010010;
    localparam logic [6:0] GLYPH_6   = 7'b0000010;
    localparam logic [6:0] GLYPH_7   = 7'b1111000;
    localparam logic [6:0] GLYPH_8   = 7'b0000000;
    localparam logic [6:0] GLYPH_9   = 7'b0010000;
    localparam logic [6:0] GLYPH_A   = 7'b0001000;
    localparam logic [6:0] GLYPH_B   = 7'b0000011;
    localparam logic [6:0] GLYPH_C   = 7'b1000110;
    localparam logic [6:0] GLYPH_D   = 7'b0100001;
    localparam logic [6:0] GLYPH_E   = 7'b0000110;
    localparam logic [6:0] GLYPH_F   = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        WAIT_SEL = 2'd0,
        SETTLE   = 2'd1,
        HOLD     = 2'd2
    } scan_state_e;

endpackage

// File: rtl/sseg_pattern_decode.sv
// Inverse glyph table: active-low segment pattern -> {ok, hex}.
// Any pattern that is not one of the 16 hex glyphs (blank included) gives ok_o=0.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic       ok_o,
    output logic [3:0] hex_o
);

    always_comb begin
        ok_o  = 1'b1;
        hex_o = 4'h0;
        case (pattern_i)
            GLYPH_0: hex_o = 4'h0;
            GLYPH_1: hex_o = 4'h1;
            GLYPH_2: hex_o = 4'h2;
            GLYPH_3: hex_o = 4'h3;
            GLYPH_4: hex_o = 4'h4;
            GLYPH_5: hex_o = 4'h5;
            GLYPH_6: hex_o = 4'h6;
            GLYPH_7: hex_o = 4'h7;
            GLYPH_8: hex_o = 4'h8;
            GLYPH_9: hex_o = 4'h9;
            GLYPH_A: hex_o = 4'hA;
            GLYPH_B: hex_o = 4'hB;
            GLYPH_C: hex_o = 4'hC;
            GLYPH_D: hex_o = 4'hD;
            GLYPH_E: hex_o = 4'hE;
            GLYPH_F: hex_o = 4'hF;
            default: ok_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/sseg_scan_capture.sv
// Reads back a multiplexed 7-seg bus: synchronises anodes/segments, waits for a slot to settle,
// decodes the glyph and keeps one hex value per digit plus frame/error status.
module sseg_scan_capture
    import sseg_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_DIGITS-1:0]     an,
    input  logic [6:0]              seg,
    output logic [4*N_DIGITS-1:0]   digits,
    output logic [N_DIGITS-1:0]     digit_valid,
    output logic                    frame_done,
    output logic                    pattern_err,
    output logic [1:0]              state_dbg
);

    localparam int ZC_W = $clog2(N_DIGITS + 1);

    logic [N_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
    logic [6:0]            seg_s1_q, seg_s2_q, seg_prev_q;
    scan_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0] digits_q, digits_d;
    logic [N_DIGITS-1:0]   valid_q, valid_d, seen_q, seen_d, seen_acc;
    logic                  frame_q, frame_d, err_q, err_d;
    logic [ZC_W-1:0]       zero_cnt;
    logic                  legal_sel, changed, capture, dec_ok;
    logic [3:0]            dec_hex;

    // Two sync stages, then a compare stage holding the previous synced sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            an_prev_q  <= '1;
            seg_s1_q   <= '1;
            seg_s2_q   <= '1;
            seg_prev_q <= '1;
        end else begin
            an_s1_q    <= an;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
            seg_s1_q   <= seg;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
        end
    end

    always_comb begin
        zero_cnt = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!an_s2_q[i]) zero_cnt = zero_cnt + 1'b1;
        end
        legal_sel = (zero_cnt == ZC_W'(1));
        changed   = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);
    end

    sseg_pattern_decode u_decode (
        .pattern_i (seg_s2_q),
        .ok_o      (dec_ok),
        .hex_o     (dec_hex)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            WAIT_SEL: begin
                cnt_d = '0;
                if (legal_sel) state_d = SETTLE;
            end
            SETTLE: begin
                if (!legal_sel) begin
                    state_d = WAIT_SEL;
                    cnt_d   = '0;
                end else if (changed) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // The edge that brings the count to SETTLE_CYCLES is the capture edge.
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        capture = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (changed || !legal_sel) begin
                    cnt_d   = '0;
                    state_d = legal_sel ? SETTLE : WAIT_SEL;
                end
            end
            default: begin
                state_d = WAIT_SEL;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        digits_d = digits_q;
        valid_d  = valid_q;
        err_d    = err_q;
        seen_d   = seen_q;
        seen_acc = seen_q;
        frame_d  = 1'b0;
        if (capture) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (!an_s2_q[i]) begin
                    if (dec_ok) begin
                        digits_d[4*i +: 4] = dec_hex;
                        valid_d[i]         = 1'b1;
                    end else begin
                        valid_d[i] = 1'b0;
                        err_d      = 1'b1;
                    end
                end
            end
            seen_acc = seen_q | ~an_s2_q;
            // The completing slot is not carried into the next frame.
            if (&seen_acc) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_acc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= WAIT_SEL;
            cnt_q    <= '0;
            digits_q <= '0;
            valid_q  <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            valid_q  <= valid_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign pattern_err = err_q;
    assign state_dbg   = state_q;

endmodule
